// File: rtl/sevseg_fx_sequencer_pkg.sv
// Shared types and constants for the seven-segment effect sequencer.
package sevseg_fx_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int IDX_W   = 3;
  localparam int SPEED_W = 4;

  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

endpackage

// File: rtl/fx_prescaler.sv
// Step-period prescaler: counts 0..limit while enabled and ticks on the terminal count.
module fx_prescaler
  import sevseg_fx_sequencer_pkg::*;
#(
  parameter int DIV_BASE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               load_limit,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int CNT_W = $clog2((2 ** SPEED_W) * DIV_BASE);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] limit_q;

  function automatic logic [CNT_W-1:0] calc_limit(input logic [SPEED_W-1:0] s);
    int unsigned p;
    p = (32'(s) + 32'd1) * 32'(DIV_BASE) - 32'd1;
    return p[CNT_W-1:0];
  endfunction

  assign tick = enable && (div_cnt_q == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      limit_q   <= CNT_W'(DIV_BASE - 1);
    end else begin
      if (clear) begin
        div_cnt_q <= '0;
      end else if (enable) begin
        div_cnt_q <= tick ? '0 : div_cnt_q + CNT_W'(1);
      end
      // The period in force is only refreshed at run entry or at a tick.
      if (load_limit) begin
        limit_q <= calc_limit(speed);
      end
    end
  end

endmodule

// File: rtl/sevseg_fx_sequencer.sv
// Seven-segment pattern sequencer: IDLE/RUN/PAUSE control, stepping and index wrap.
// Define SEVSEG_FX_BOUNCE_EN for ping-pong index motion instead of 7<->0 wrapping.
module sevseg_fx_sequencer
  import sevseg_fx_sequencer_pkg::*;
#(
  parameter int DIV_BASE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic               i_step,
  input  logic               i_dir,
  input  logic [SPEED_W-1:0] i_speed,
  output logic [IDX_W-1:0]   o_count,
  output logic [1:0]         o_state,
  output logic               o_busy,
  output logic               o_wrap,
  output logic               o_step_ack
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q;
  logic             busy_q;
  logic             wrap_q;
  logic             ack_q, ack_d;
  logic             adv;
  logic             run_entry;
  logic             run_tick;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;
  logic             pre_load;
  logic [IDX_W-1:0] adv_count;
  logic             adv_wrap;

  assign pre_en   = (state_q == ST_RUN);
  assign pre_clr  = i_stop | run_entry;
  assign pre_load = run_entry | run_tick;

  fx_prescaler #(
    .DIV_BASE (DIV_BASE)
  ) u_prescaler (
    .clk        (i_clk),
    .rst        (i_rst),
    .enable     (pre_en),
    .clear      (pre_clr),
    .load_limit (pre_load),
    .speed      (i_speed),
    .tick       (tick)
  );

  // Command priority: stop > start > pause > step.
  always_comb begin
    state_d   = state_q;
    adv       = 1'b0;
    ack_d     = 1'b0;
    run_entry = 1'b0;
    run_tick  = 1'b0;
    if (i_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d   = ST_RUN;
            run_entry = 1'b1;
          end else if (!i_pause && i_step) begin
            adv   = 1'b1;
            ack_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            adv      = 1'b1;
            run_tick = 1'b1;
          end
          if (!i_start && i_pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (i_start) begin
            state_d = ST_RUN;
          end else if (!i_pause && i_step) begin
            adv   = 1'b1;
            ack_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef SEVSEG_FX_BOUNCE_EN
  logic dir_q, dir_d;
  logic eff_rev;

  // At either end the motion is forced back inward, so 7<->0 can never happen.
  always_comb begin
    eff_rev   = (count_q == IDX_MAX) || (dir_q && (count_q != '0));
    adv_count = eff_rev ? count_q - IDX_W'(1) : count_q + IDX_W'(1);
    adv_wrap  = (adv_count == IDX_MAX) || (adv_count == '0);
    dir_d     = dir_q;
    if (run_entry) begin
      dir_d = i_dir;
    end else if (adv) begin
      if (adv_count == IDX_MAX) begin
        dir_d = 1'b1;
      end else if (adv_count == '0) begin
        dir_d = 1'b0;
      end else begin
        dir_d = eff_rev;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  always_comb begin
    adv_count = i_dir ? count_q - IDX_W'(1) : count_q + IDX_W'(1);
    adv_wrap  = i_dir ? (count_q == '0) : (count_q == IDX_MAX);
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      wrap_q  <= adv & adv_wrap;
      ack_q   <= ack_d;
      if (i_stop) begin
        count_q <= '0;
      end else if (adv) begin
        count_q <= adv_count;
      end
    end
  end

  assign o_count    = count_q;
  assign o_state    = state_q;
  assign o_busy     = busy_q;
  assign o_wrap     = wrap_q;
  assign o_step_ack = ack_q;

endmodule

// File: doc/sevseg_fx_sequencer.md
SEVSEG_FX_SEQUENCER -- requirements
Module: sevseg_fx_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DIV_BASE, default 4: base prescale unit in clock cycles, range 1..4096.
REQ-003 Port i_clk, input, 1 bit: sole clock, all state on rising edge.
REQ-004 Port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port i_start, input, 1 bit: start from IDLE, or resume from PAUSE.
REQ-006 Port i_stop, input, 1 bit: abort to IDLE and clear the index.
REQ-007 Port i_pause, input, 1 bit: freeze in PAUSE while running.
REQ-008 Port i_step, input, 1 bit: single-step request, honoured in IDLE or PAUSE only.
REQ-009 Port i_dir, input, 1 bit: 0 = forward (+1), 1 = reverse (-1).
REQ-010 Port i_speed, input, 4 bits: step period = (i_speed+1)*DIV_BASE cycles.
REQ-011 Port o_count, output, 3 bits: pattern index that drives the segment decoder.
REQ-012 Port o_state, output, 2 bits: 0 IDLE, 1 RUN, 2 PAUSE.
REQ-013 Port o_busy, output, 1 bit: high only in RUN.
REQ-014 Port o_wrap, output, 1 bit: one-cycle pulse on index wrap (or on reversal, see REQ-030).
REQ-015 Port o_step_ack, output, 1 bit: one-cycle pulse for each step that is honoured.

Function
REQ-016 Prescaler: div_cnt counts 0..LIMIT with LIMIT=(i_speed+1)*DIV_BASE-1; tick is asserted in the cycle div_cnt==LIMIT, and div_cnt then returns to 0.
REQ-017 i_speed SHALL be sampled into LIMIT only on entry to RUN and at each tick; mid-period changes take effect on the next period.
REQ-018 Command priority in one cycle: i_stop > i_start > i_pause > i_step.
REQ-019 IDLE: i_start -> RUN with div_cnt=0, so the first advance occurs LIMIT+1 cycles after the start edge.
REQ-020 RUN: o_count advances by one on each tick; i_pause -> PAUSE.
REQ-021 PAUSE: o_count and div_cnt are held; i_start -> RUN, resuming with the remaining period; no re-sample of i_speed occurs on resume.
REQ-022 i_stop in any state -> IDLE next cycle, o_count=0, div_cnt=0; o_wrap and o_step_ack remain low in that cycle.
REQ-023 i_step in IDLE/PAUSE advances o_count by one in the current direction and raises o_step_ack for that same edge; i_step in RUN is ignored with no ack.
REQ-024 A held i_step yields one advance per cycle (no edge detection); the requester deasserts on ack.
REQ-025 Forward: 7 -> 0 wraps; reverse: 0 -> 7 wraps; each wrap pulses o_wrap together with the index update.
REQ-026 In a cycle where a tick and i_pause coincide, the tick advance is applied and then the block enters PAUSE.
REQ-027 o_state, o_busy and o_count are registered outputs; there is no combinational path from any input to any output.

Reset
REQ-028 While i_rst is high: state=IDLE, o_count=0, div_cnt=0, LIMIT=DIV_BASE-1, direction=forward, o_wrap=0, o_step_ack=0, o_busy=0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately; after release, the block waits in IDLE for i_start.

Configuration
REQ-030 With SEVSEG_FX_BOUNCE_EN defined: ping-pong mode. Direction is loaded from i_dir on IDLE->RUN only. On reaching 7 going forward, the direction flips to reverse; on reaching 0 going reverse, it flips to forward. o_wrap pulses on the step that reaches the end. No 7<->0 wrap ever occurs.
REQ-031 Without SEVSEG_FX_BOUNCE_EN: i_dir is sampled at every advance (tick or step), and wrap behaviour follows REQ-025.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE/RUN/PAUSE), the index width (3), the speed width (4) and the index max (7).
REQ-033 The prescaler SHALL be a sub-module fx_prescaler (inputs: enable, clear, load limit; output: tick); the FSM and index logic stay in sevseg_fx_sequencer.

Verification (DIV_BASE=4)
REQ-034 Reset, then i_speed=1, pulse i_start -> first advance 8 cycles later, o_count 0,1,2.. every 8 cycles, o_busy=1.
REQ-035 RUN forward from 6 -> o_count 7 then 0, with o_wrap high exactly on the 7->0 update; i_dir=1 from 1 -> 0, then 7 with o_wrap.
REQ-036 i_pause 3 cycles into a period at count=4, hold 20 cycles, i_start -> count stays 4, then advances 5 cycles after resume.
REQ-037 In PAUSE, 3-cycle i_step with i_dir=0 from count=2 -> count 3,4,5 and three o_step_ack pulses; the same stimulus in RUN -> no ack.
REQ-038 i_stop and i_start in the same cycle during RUN at count=5 -> IDLE, count=0; async i_rst mid-period -> outputs reset without a clock edge.
REQ-039 SEVSEG_FX_BOUNCE_EN defined, forward from 0 -> sequence 1..7,6..0,1, with o_wrap on reaching 7 and on reaching 0.
